// File: rtl/common_pkg.sv
// Shared fetch-side types: reset vector, fetch FSM states and instruction bus structs.
package common;

  typedef logic [63:0] word_t;

  localparam word_t PC_RESET = 64'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic  valid;
    word_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic  data_ok;
    word_t data;
  } ibus_resp_t;

endpackage

// File: rtl/temp_storage.sv
// Pipeline latch types between stages; if_id carries the fetched instruction to decode.
package temp_storage;

  typedef struct packed {
    logic [31:0]  inst;
    common::word_t inst_pc;
    logic         inst_signal;
  } if_id;

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage with redirect/flush handling.
// Optional FETCH_MISALIGN_EN: misaligned PC blocks fetch and raises a sticky fetch_misalign.
module fetch_unit
  import common::*;
  import temp_storage::*;
(
  input  logic         clk,
  input  logic         rst,
  output ibus_req_t    ireq,
  input  ibus_resp_t   iresp,
  input  logic         stall,
  input  logic         redirect_valid,
  input  word_t        redirect_pc,
  output if_id         if_id_state,
`ifdef FETCH_MISALIGN_EN
  output logic         fetch_misalign,
`endif
  output fetch_state_t dbg_state
);

  fetch_state_t state, state_next;
  word_t        pc;
  word_t        req_addr;
  logic         out_valid;
  logic [31:0]  out_inst;
  word_t        out_pc;

  logic slot_free;
  logic start_req;
  logic load_out;
  logic misalign_hit;
  logic unused_data_hi;

  assign unused_data_hi = ^iresp.data[63:32];

  // Bus handshake: valid rises with addr and both stay fixed until the cycle
  // data_ok is seen; data_ok completes the transaction in that same cycle.
  assign ireq.valid = (state == BUSY || state == FLUSH) && !rst;
  assign ireq.addr  = req_addr;

  assign if_id_state.inst        = out_inst;
  assign if_id_state.inst_pc     = out_pc;
  assign if_id_state.inst_signal = out_valid;
  assign dbg_state               = state;

  always_comb begin
    state_next = state;
    start_req  = 1'b0;
    load_out   = 1'b0;
    slot_free  = !out_valid || !stall;
`ifdef FETCH_MISALIGN_EN
    misalign_hit = fetch_misalign || (pc[1:0] != 2'b00);
`else
    misalign_hit = 1'b0;
`endif
    if (redirect_valid) begin
      // An in-flight request cannot be withdrawn; drain it in FLUSH unless it ends now.
      if (state != IDLE && !iresp.data_ok) state_next = FLUSH;
      else                                 state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!misalign_hit && slot_free) begin
            state_next = BUSY;
            start_req  = 1'b1;
          end
        end
        BUSY: begin
          if (iresp.data_ok) begin
            state_next = IDLE;
            load_out   = 1'b1;
          end
        end
        FLUSH: begin
          if (iresp.data_ok) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= PC_RESET;
      req_addr  <= '0;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
`ifdef FETCH_MISALIGN_EN
      fetch_misalign <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        pc        <= redirect_pc;
        out_valid <= 1'b0;
`ifdef FETCH_MISALIGN_EN
        fetch_misalign <= 1'b0;
`endif
      end else begin
        if (start_req) req_addr <= {pc[63:2], 2'b00};
`ifdef FETCH_MISALIGN_EN
        if (state == IDLE && misalign_hit) fetch_misalign <= 1'b1;
`endif
        if (load_out) begin
          out_inst  <= iresp.data[31:0];
          out_pc    <= req_addr;
          out_valid <= 1'b1;
          pc        <= pc + 64'd4;
        end else if (!stall) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have ports: clk  input  1  pipeline clock.
REQ-002 rst  input  1  reset, synchronous, active-high, sampled on the rising edge of clk.
REQ-003 ireq  output  ibus_req_t  instruction bus request: valid, addr.
REQ-004 iresp  input  ibus_resp_t  instruction bus response: data_ok, data (low 32 bits carry the instruction).
REQ-005 stall  input  1  decode stage cannot accept if_id_state this cycle.
REQ-006 redirect_valid  input  1  branch/jump/exception redirect.
REQ-007 redirect_pc  input  word_t  redirect target.
REQ-008 if_id_state  output  if_id  registered {inst, inst_pc, inst_signal}; inst_signal=1 marks a valid instruction.
REQ-009 fetch_misalign  output  1  misaligned-PC fault flag; exists only under FETCH_MISALIGN_EN.

Function
REQ-010 Internal registers SHALL be: pc, req_addr, out_valid, out_inst, out_pc, and a state machine with states IDLE, BUSY, FLUSH.
REQ-011 ireq.valid SHALL be 1 exactly in BUSY and FLUSH; ireq.addr SHALL equal req_addr, held constant until data_ok.
REQ-012 IDLE -> BUSY SHALL occur when the slot is free (!out_valid or !stall) and no redirect is present; req_addr<=pc on that edge.
REQ-013 BUSY with data_ok and no redirect SHALL load out_inst<=iresp.data[31:0], out_pc<=req_addr, out_valid<=1, pc<=pc+4 (word_t width, wrap modulo 2^64), and go to IDLE.
REQ-014 BUSY with redirect_valid SHALL set pc<=redirect_pc, out_valid<=0, and go to IDLE if data_ok in the same cycle (response dropped), else to FLUSH.
REQ-015 FLUSH SHALL keep the request asserted and drop the response; on data_ok it goes to IDLE; no output is loaded.
REQ-016 redirect_valid in any state SHALL set pc<=redirect_pc and clear out_valid; the last redirect wins; redirect has priority over data_ok and stall.
REQ-017 out_valid SHALL clear when !stall and no new load occurs; while stall=1 the output registers SHALL hold unchanged.
REQ-018 if_id_state SHALL be driven directly from the output registers (inst_signal=out_valid).
REQ-019 Latency: data_ok in cycle N SHALL give inst_signal=1 in cycle N+1; peak throughput is one instruction per 3 cycles with a single-cycle-response bus.
REQ-020 At most one bus transaction SHALL be outstanding; a request SHALL never be withdrawn before data_ok.

Reset
REQ-021 On rst=1: pc<=PC_RESET (64'h8000_0000), req_addr<=0, state<=IDLE, out_valid<=0, out_inst<=0, out_pc<=0, fetch_misalign<=0; ireq.valid=0 in the reset cycle.
REQ-022 rst asserted mid-transaction SHALL abandon the transaction: no FLUSH, and the late data_ok is ignored in IDLE.

Configuration
REQ-023 Macro FETCH_MISALIGN_EN defined: in IDLE, pc[1:0]!=0 SHALL block the request and set fetch_misalign<=1 (sticky); only redirect or reset clears it and resumes fetch.
REQ-024 Macro undefined: fetch_misalign port absent; req_addr SHALL load {pc[63:2],2'b00} and fetch proceeds.

Structure
REQ-025 PC_RESET, the fetch state enum, ibus_req_t and ibus_resp_t SHALL live in package common; if_id SHALL live in temp_storage.
REQ-026 No sub-module; a single module with one always_ff and one always_comb next-state block.

Verification
REQ-027 Reset release, memory returns data_ok one cycle after each request with 32'h00000093 -> ireq.addr 0x80000000 then 0x80000004; inst_signal pulses with inst_pc 0x80000000, 0x80000004.
REQ-028 stall=1 for 4 cycles while out_valid=1 -> if_id_state unchanged, ireq.valid=0 throughout; next fetch starts the cycle after stall drops.
REQ-029 redirect to 0x80001000 in BUSY, data_ok 3 cycles later -> FLUSH entered, that response dropped, next ireq.addr=0x80001000.
REQ-030 redirect and data_ok in the same cycle -> no inst_signal, next request to redirect_pc.
REQ-031 FETCH_MISALIGN_EN, redirect to 0x80000002 -> fetch_misalign=1, no request; redirect to 0x80000100 clears it and fetch resumes.
REQ-032 rst pulsed while BUSY -> state IDLE, next ireq.addr 0x80000000, stray data_ok ignored.
